wb_intercon: RTL and testbench
==============================

# wb_intercon

Parametrised Wishbone classic interconnect that replaces the fixed CPU-only bus in the SoC top. It arbitrates `NM` masters (CPU, DMA, …) with round-robin fairness, decodes one of `NS` slaves through per-slave base/mask parameters, and routes data and acknowledge between them. Unmapped accesses and slaves that fail to acknowledge are terminated by the interconnect itself. Each such event returns `ERR_DATA` and is logged in error-status outputs, so a bad access can never hang the bus.

## Interface
Parameters:
- `NM`, 2: number of masters (1..8); index 0 = CPU.
- `NS`, 4: number of slaves (1..16).
- `S_BASE`, {32'hf000_0000, 32'he000_0000, 32'h4000_0000, 32'h0000_0000}: NS×32 base vector; slave i at `[i*32+:32]`.
- `S_MASK`, {32'hf000_0000, 32'hf000_0000, 32'hf000_0000, 32'hffff_e000}: NS×32 mask vector; slave i selected when `(adr & mask_i) == base_i`.
- `TIMEOUT`, 255: cycles without slave ack before forced termination (2..65535).
- `ERR_DATA`, 32'hffff_ffff: read data returned on error termination.

Ports:
- `sys_clk`  in  1  system clock; all logic rising-edge.
- `sys_rstn`  in  1  reset, synchronous, active-low.
- `m_adr_i`, `m_dat_i`  in  NM×32  master address / write data.
- `m_sel_i`  in  NM×4  master byte selects.
- `m_we_i`, `m_stb_i`, `m_cyc_i`  in  NM  master controls.
- `m_dat_o`  out  NM×32  read data to masters.
- `m_ack_o`  out  NM  acknowledge to masters.
- `s_adr_o`, `s_dat_o`  out  32  shared address / write data.
- `s_sel_o`  out  4  shared byte selects.
- `s_we_o`  out  1  shared write enable.
- `s_stb_o`, `s_cyc_o`  out  NS  per-slave strobe / cycle (decoded).
- `s_dat_i`  in  NS×32  slave read data.
- `s_ack_i`  in  NS  slave acknowledges.
- `err_clr`  in  1  clear error status (one-cycle pulse).
- `bus_err`  out  1  sticky error flag.
- `err_adr`  out  32  address of most recent error.
- `err_cnt`  out  8  saturating error count.

## Operation
- States: IDLE, BUSY, EACK.
- IDLE: when any `m_cyc_i` is high, register the grant. Search starts at `last+1`, wraps modulo NM, and takes the first requester. Go to BUSY. `last` resets to NM-1, so master 0 wins first.
- BUSY: the granted master's adr/dat/sel/we drive the shared slave outputs. The decoded slave index is the lowest matching i. The decoded slave gets `s_cyc_o = m_cyc`, `s_stb_o = m_stb`; all other slaves get 0.
- BUSY routing: the slave's `s_ack_i`/`s_dat_i` pass combinationally to the granted master. Non-granted masters see `m_ack_o = 0` and `m_dat_o = 0`.
- BUSY, unmapped: stb high with no match → EACK.
- BUSY, timeout: a 16-bit counter increments each cycle stb is high on a mapped slave without ack, and clears on ack or when stb is low. Reaching TIMEOUT → EACK, with that slave's stb/cyc forced low from that cycle on.
- EACK: lasts one cycle. `m_ack_o` = 1 and `m_dat_o = ERR_DATA` to the granted master. All `s_stb_o`/`s_cyc_o` = 0. Error logged. Return to BUSY.
- Release: in BUSY, granted `m_cyc_i` low → `last` = grant, go to IDLE. A grant is never preempted while cyc is held.
- Error log: sets `bus_err`, loads `err_adr` = failing address, increments `err_cnt` (saturates at 255). `err_clr` zeroes all three. If `err_clr` and a new error coincide, the new error wins: flag = 1, cnt = 1, adr loaded.

## Timing
- Reset (`sys_rstn` low at an edge): state = IDLE, `last` = NM-1, counter = 0. All outputs 0: acks, stbs, cycs, `s_*`, `m_dat_o`, `bus_err`, `err_adr`, `err_cnt`.
- Reset mid-transaction: the transfer is aborted with no ack. Slaves see cyc/stb low on the next cycle.
- Arbitration latency: cyc high in cycle 0 → slave strobe in cycle 1. Once granted, back-to-back transfers within the same cyc have zero added latency.
- Slave ack to master: same cycle (combinational).
- Unmapped access: stb seen in BUSY cycle n → ack in cycle n+1.
- Timeout: stb high from cycle n with no ack → error ack in cycle n+TIMEOUT.
- Slave ack arriving in the cycle the counter reaches TIMEOUT: the slave ack wins; no error is logged.
- Two masters raising cyc in the same cycle: grant follows round-robin order.

## Test plan
- Reset, then CPU (m0) reads 0x0000_0010 from a slave-3 model acking 1 cycle later with data 0x1234_5678 → `s_stb_o` = 4'b1000 in cycle 1; m0 receives 0x1234_5678 with one ack.
- m0 and m1 assert cyc together, each doing 3 single transfers with cyc dropped between them → grant order m0, m1, m0, m1, m0, m1; no ack ever reaches a non-granted master.
- m0 reads 0x8000_0000 (unmapped) → ack one cycle after the strobe, data 0xffff_ffff, `bus_err` = 1, `err_adr` = 0x8000_0000, `err_cnt` = 1.
- The slave at 0xf000_0000 never acks, with TIMEOUT = 8 → ack exactly 8 cycles after the strobe, data 0xffff_ffff, slave stb low from the forced-ack cycle; `err_cnt` increments.
- The slave acks in the same cycle the timeout would fire → slave data delivered, `err_cnt` unchanged. Then pulse `err_clr` together with a new unmapped error → `bus_err` = 1, `err_cnt` = 1.
- Drive `sys_rstn` low during a pending slave access → all outputs 0 on the next edge; after release, m0 is granted first.

Source files
------------

// File: rtl/wb_intercon.sv
// Wishbone classic interconnect: round-robin arbitration across NM masters, base/mask decode
// to NS slaves, and interconnect-generated termination for unmapped or unresponsive accesses.
module wb_intercon #(
  parameter int          NM       = 2,
  parameter int          NS       = 4,
  parameter logic [NS*32-1:0] S_BASE = {32'hf000_0000, 32'he000_0000, 32'h4000_0000, 32'h0000_0000},
  parameter logic [NS*32-1:0] S_MASK = {32'hf000_0000, 32'hf000_0000, 32'hf000_0000, 32'hffff_e000},
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hffff_ffff
) (
  input  logic               sys_clk,
  input  logic               sys_rstn,
  input  logic [NM*32-1:0]   m_adr_i,
  input  logic [NM*32-1:0]   m_dat_i,
  input  logic [NM*4-1:0]    m_sel_i,
  input  logic [NM-1:0]      m_we_i,
  input  logic [NM-1:0]      m_stb_i,
  input  logic [NM-1:0]      m_cyc_i,
  output logic [NM*32-1:0]   m_dat_o,
  output logic [NM-1:0]      m_ack_o,
  output logic [31:0]        s_adr_o,
  output logic [31:0]        s_dat_o,
  output logic [3:0]         s_sel_o,
  output logic               s_we_o,
  output logic [NS-1:0]      s_stb_o,
  output logic [NS-1:0]      s_cyc_o,
  input  logic [NS*32-1:0]   s_dat_i,
  input  logic [NS-1:0]      s_ack_i,
  input  logic               err_clr,
  output logic               bus_err,
  output logic [31:0]        err_adr,
  output logic [7:0]         err_cnt
);
  localparam int GW = (NM > 1) ? $clog2(NM) : 1;
  localparam int SW = (NS > 1) ? $clog2(NS) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, EACK} state_t;

  state_t        state;
  logic [GW-1:0] grant, last, next_grant;
  logic [15:0]   tmo_cnt;

  logic [31:0]   g_adr, g_dat;
  logic [3:0]    g_sel;
  logic          g_we, g_stb, g_cyc;
  logic          hit, s_ack, err_evt;
  logic [SW-1:0] sidx;
  logic [31:0]   s_rdat;

  always_comb begin
    g_adr = m_adr_i[32*grant +: 32];
    g_dat = m_dat_i[32*grant +: 32];
    g_sel = m_sel_i[4*grant +: 4];
    g_we  = m_we_i[grant];
    g_stb = m_stb_i[grant];
    g_cyc = m_cyc_i[grant];
  end

  // Round-robin: walk down so the first requester after 'last' overwrites the rest.
  always_comb begin
    next_grant = last;
    for (int k = NM; k >= 1; k--)
      if (m_cyc_i[(int'(last) + k) % NM]) next_grant = GW'((int'(last) + k) % NM);
  end

  // Lowest matching slave wins, hence the descending scan.
  always_comb begin
    hit  = 1'b0;
    sidx = '0;
    for (int i = NS-1; i >= 0; i--)
      if ((g_adr & S_MASK[i*32 +: 32]) == S_BASE[i*32 +: 32]) begin
        hit  = 1'b1;
        sidx = SW'(i);
      end
    s_ack  = s_ack_i[sidx];
    s_rdat = s_dat_i[32*sidx +: 32];
  end

  // A slave ack in the terminal timeout cycle suppresses the forced termination.
  assign err_evt = (state == BUSY) && g_cyc && g_stb &&
                   (!hit || (!s_ack && tmo_cnt == 16'(TIMEOUT-1)));

  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_stb_o = '0;
    s_cyc_o = '0;
    m_ack_o = '0;
    m_dat_o = '0;
    if (state == BUSY) begin
      s_adr_o = g_adr;
      s_dat_o = g_dat;
      s_sel_o = g_sel;
      s_we_o  = g_we;
      if (hit) begin
        s_cyc_o[sidx]           = g_cyc;
        s_stb_o[sidx]           = g_stb;
        m_ack_o[grant]          = g_cyc & g_stb & s_ack;
        m_dat_o[32*grant +: 32] = s_rdat;
      end
    end else if (state == EACK) begin
      m_ack_o[grant]          = 1'b1;
      m_dat_o[32*grant +: 32] = ERR_DATA;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rstn) begin
      state   <= IDLE;
      last    <= GW'(NM-1);
      grant   <= '0;
      tmo_cnt <= '0;
      bus_err <= 1'b0;
      err_adr <= '0;
      err_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (|m_cyc_i) begin
          grant <= next_grant;
          state <= BUSY;
        end
        BUSY: begin
          if (!g_cyc) begin
            last    <= grant;
            state   <= IDLE;
            tmo_cnt <= '0;
          end else if (err_evt) begin
            state   <= EACK;
            tmo_cnt <= '0;
          end else if (g_stb && !s_ack) begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end else begin
            tmo_cnt <= '0;
          end
        end
        EACK:    state <= BUSY;
        default: state <= IDLE;
      endcase

      if (err_evt) begin
        bus_err <= 1'b1;
        err_adr <= g_adr;
        if (err_clr)               err_cnt <= 8'd1;
        else if (err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
      end else if (err_clr) begin
        bus_err <= 1'b0;
        err_adr <= '0;
        err_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_wb_intercon.sv
// Directed bench for wb_intercon: reset, single read, round-robin, unmapped, timeout,
// ack-at-timeout, error clear collision, and reset during an access.
module tb_wb_intercon;
  localparam int NM  = 2;
  localparam int NS  = 4;
  localparam int TMO = 8;

  logic              sys_clk = 1'b0;
  logic              sys_rstn;
  logic [NM*32-1:0]  m_adr_i, m_dat_i, m_dat_o;
  logic [NM*4-1:0]   m_sel_i;
  logic [NM-1:0]     m_we_i, m_stb_i, m_cyc_i, m_ack_o;
  logic [31:0]       s_adr_o, s_dat_o;
  logic [3:0]        s_sel_o;
  logic              s_we_o;
  logic [NS-1:0]     s_stb_o, s_cyc_o, s_ack_i;
  logic [NS*32-1:0]  s_dat_i;
  logic              err_clr, bus_err;
  logic [31:0]       err_adr;
  logic [7:0]        err_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  // Slave 0 = 0xf000_0000 region, slave 3 = 0x0000_0000..0x1fff, so 0x10 lands on slave 3.
  wb_intercon #(
    .NM(NM), .NS(NS),
    .S_BASE({32'h0000_0000, 32'h4000_0000, 32'he000_0000, 32'hf000_0000}),
    .S_MASK({32'hffff_e000, 32'hf000_0000, 32'hf000_0000, 32'hf000_0000}),
    .TIMEOUT(TMO), .ERR_DATA(32'hffff_ffff)
  ) dut (
    .sys_clk(sys_clk), .sys_rstn(sys_rstn),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
    .m_stb_i(m_stb_i), .m_cyc_i(m_cyc_i), .m_dat_o(m_dat_o), .m_ack_o(m_ack_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .err_clr(err_clr), .bus_err(bus_err), .err_adr(err_adr), .err_cnt(err_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic settle();
    @(negedge sys_clk);
  endtask

  task automatic mreq(input int m, input logic on, input logic [31:0] adr);
    m_cyc_i[m]          = on;
    m_stb_i[m]          = on;
    m_we_i[m]           = 1'b0;
    m_adr_i[m*32 +: 32] = adr;
    m_dat_i[m*32 +: 32] = 32'h0;
    m_sel_i[m*4 +: 4]   = 4'hf;
  endtask

  task automatic test_reset();
    sys_rstn = 1'b0;
    m_adr_i = '0; m_dat_i = '0; m_sel_i = '0; m_we_i = '0; m_stb_i = '0; m_cyc_i = '0;
    s_dat_i = '0; s_ack_i = '0; err_clr = 1'b0;
    step(); step(); settle();
    n_chk++; if (m_ack_o !== 2'b00) begin n_fail++; $display("FAIL reset_ack: got %b want 00", m_ack_o); end
    n_chk++; if (s_stb_o !== 4'b0) begin n_fail++; $display("FAIL reset_stb: got %b want 0000", s_stb_o); end
    n_chk++; if (s_cyc_o !== 4'b0) begin n_fail++; $display("FAIL reset_cyc: got %b want 0000", s_cyc_o); end
    n_chk++; if (s_adr_o !== 32'h0) begin n_fail++; $display("FAIL reset_adr: got %h want 0", s_adr_o); end
    n_chk++; if (m_dat_o !== 64'h0) begin n_fail++; $display("FAIL reset_mdat: got %h want 0", m_dat_o); end
    n_chk++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL reset_bus_err: got %b want 0", bus_err); end
    n_chk++; if (err_cnt !== 8'h0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
    n_chk++; if (err_adr !== 32'h0) begin n_fail++; $display("FAIL reset_err_adr: got %h want 0", err_adr); end
    sys_rstn = 1'b1;
    step(); settle();
  endtask

  task automatic test_round_robin();
    int rem[2];
    rem[0] = 3; rem[1] = 3;
    mreq(0, 1'b1, 32'h0000_0100);
    mreq(1, 1'b1, 32'h4000_0000);
    for (int i = 0; i < 6; i++) begin
      int g;
      logic [31:0] ea, ed;
      logic [3:0]  es;
      logic [1:0]  eack;
      g    = i % 2;
      ea   = (g == 1) ? 32'h4000_0000 : 32'h0000_0100;
      es   = (g == 1) ? 4'b0100 : 4'b1000;
      eack = (g == 1) ? 2'b10 : 2'b01;
      ed   = 32'ha500_0000 + 32'(i);
      step(); settle();
      n_chk++; if (s_adr_o !== ea) begin n_fail++; $display("FAIL rr_grant_adr[%0d]: got %h want %h", i, s_adr_o, ea); end
      n_chk++; if (s_stb_o !== es) begin n_fail++; $display("FAIL rr_stb[%0d]: got %b want %b", i, s_stb_o, es); end
      s_ack_i = es;
      s_dat_i = {4{ed}};
      #1;
      n_chk++; if (m_ack_o !== eack) begin n_fail++; $display("FAIL rr_ack[%0d]: got %b want %b", i, m_ack_o, eack); end
      n_chk++; if (m_dat_o[g*32 +: 32] !== ed) begin n_fail++; $display("FAIL rr_dat[%0d]: got %h want %h", i, m_dat_o[g*32 +: 32], ed); end
      n_chk++; if (m_dat_o[(1-g)*32 +: 32] !== 32'h0) begin n_fail++; $display("FAIL rr_other_dat[%0d]: got %h want 0", i, m_dat_o[(1-g)*32 +: 32]); end
      step();
      mreq(g, 1'b0, 32'h0);
      s_ack_i = '0;
      settle();
      n_chk++; if (m_ack_o !== 2'b00) begin n_fail++; $display("FAIL rr_release_ack[%0d]: got %b want 00", i, m_ack_o); end
      step();
      rem[g]--;
      if (rem[g] > 0) mreq(g, 1'b1, ea);
      settle();
      n_chk++; if (m_ack_o !== 2'b00) begin n_fail++; $display("FAIL rr_idle_ack[%0d]: got %b want 00", i, m_ack_o); end
    end
  endtask

  task automatic test_single_read();
    mreq(0, 1'b1, 32'h0000_0010);
    #1;
    n_chk++; if (s_stb_o !== 4'b0000) begin n_fail++; $display("FAIL sr_stb_c0: got %b want 0000", s_stb_o); end
    step(); settle();
    n_chk++; if (s_stb_o !== 4'b1000) begin n_fail++; $display("FAIL sr_stb_c1: got %b want 1000", s_stb_o); end
    n_chk++; if (s_cyc_o !== 4'b1000) begin n_fail++; $display("FAIL sr_cyc_c1: got %b want 1000", s_cyc_o); end
    n_chk++; if (s_adr_o !== 32'h10) begin n_fail++; $display("FAIL sr_adr: got %h want 00000010", s_adr_o); end
    n_chk++; if (m_ack_o !== 2'b00) begin n_fail++; $display("FAIL sr_early_ack: got %b want 00", m_ack_o); end
    step();
    s_ack_i = 4'b1000;
    s_dat_i[3*32 +: 32] = 32'h1234_5678;
    settle();
    n_chk++; if (m_ack_o !== 2'b01) begin n_fail++; $display("FAIL sr_ack: got %b want 01", m_ack_o); end
    n_chk++; if (m_dat_o[31:0] !== 32'h1234_5678) begin n_fail++; $display("FAIL sr_dat: got %h want 12345678", m_dat_o[31:0]); end
    n_chk++; if (m_dat_o[63:32] !== 32'h0) begin n_fail++; $display("FAIL sr_m1_dat: got %h want 0", m_dat_o[63:32]); end
    step();
    mreq(0, 1'b0, 32'h0);
    s_ack_i = '0;
    settle();
    n_chk++; if (m_ack_o !== 2'b00) begin n_fail++; $display("FAIL sr_single_ack: got %b want 00", m_ack_o); end
    step(); settle();
  endtask

  task automatic test_unmapped();
    mreq(0, 1'b1, 32'h8000_0000);
    step(); settle();
    n_chk++; if (s_stb_o !== 4'b0000) begin n_fail++; $display("FAIL um_stb: got %b want 0000", s_stb_o); end
    n_chk++; if (m_ack_o !== 2'b00) begin n_fail++; $display("FAIL um_early_ack: got %b want 00", m_ack_o); end
    step(); settle();
    n_chk++; if (m_ack_o !== 2'b01) begin n_fail++; $display("FAIL um_ack: got %b want 01", m_ack_o); end
    n_chk++; if (m_dat_o[31:0] !== 32'hffff_ffff) begin n_fail++; $display("FAIL um_dat: got %h want ffffffff", m_dat_o[31:0]); end
    n_chk++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL um_bus_err: got %b want 1", bus_err); end
    n_chk++; if (err_adr !== 32'h8000_0000) begin n_fail++; $display("FAIL um_err_adr: got %h want 80000000", err_adr); end
    n_chk++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL um_err_cnt: got %0d want 1", err_cnt); end
    step();
    mreq(0, 1'b0, 32'h0);
    settle();
    n_chk++; if (m_ack_o !== 2'b00) begin n_fail++; $display("FAIL um_after_ack: got %b want 00", m_ack_o); end
    step(); settle();
  endtask

  task automatic test_timeout();
    mreq(0, 1'b1, 32'hf000_0040);
    step();
    for (int k = 0; k < TMO; k++) begin
      settle();
      n_chk++; if (s_stb_o !== 4'b0001) begin n_fail++; $display("FAIL to_stb[%0d]: got %b want 0001", k, s_stb_o); end
      n_chk++; if (m_ack_o !== 2'b00) begin n_fail++; $display("FAIL to_early_ack[%0d]: got %b want 00", k, m_ack_o); end
      step();
    end
    settle();
    n_chk++; if (m_ack_o !== 2'b01) begin n_fail++; $display("FAIL to_ack: got %b want 01", m_ack_o); end
    n_chk++; if (m_dat_o[31:0] !== 32'hffff_ffff) begin n_fail++; $display("FAIL to_dat: got %h want ffffffff", m_dat_o[31:0]); end
    n_chk++; if (s_stb_o !== 4'b0000) begin n_fail++; $display("FAIL to_stb_forced: got %b want 0000", s_stb_o); end
    n_chk++; if (s_cyc_o !== 4'b0000) begin n_fail++; $display("FAIL to_cyc_forced: got %b want 0000", s_cyc_o); end
    n_chk++; if (err_cnt !== 8'd2) begin n_fail++; $display("FAIL to_err_cnt: got %0d want 2", err_cnt); end
    n_chk++; if (err_adr !== 32'hf000_0040) begin n_fail++; $display("FAIL to_err_adr: got %h want f0000040", err_adr); end
    step();
    mreq(0, 1'b0, 32'h0);
    settle();
    n_chk++; if (m_ack_o !== 2'b00) begin n_fail++; $display("FAIL to_after_ack: got %b want 00", m_ack_o); end
    step(); settle();
  endtask

  task automatic test_ack_at_timeout_and_clr();
    mreq(0, 1'b1, 32'he000_0000);
    step();
    for (int k = 0; k < TMO-1; k++) begin
      settle();
      n_chk++; if (m_ack_o !== 2'b00) begin n_fail++; $display("FAIL at_early_ack[%0d]: got %b want 00", k, m_ack_o); end
      step();
    end
    s_ack_i = 4'b0010;
    s_dat_i[1*32 +: 32] = 32'hcafe_f00d;
    settle();
    n_chk++; if (m_ack_o !== 2'b01) begin n_fail++; $display("FAIL at_ack: got %b want 01", m_ack_o); end
    n_chk++; if (m_dat_o[31:0] !== 32'hcafe_f00d) begin n_fail++; $display("FAIL at_dat: got %h want cafef00d", m_dat_o[31:0]); end
    step();
    s_ack_i = '0;
    mreq(0, 1'b0, 32'h0);
    settle();
    n_chk++; if (m_ack_o !== 2'b00) begin n_fail++; $display("FAIL at_no_err_ack: got %b want 00", m_ack_o); end
    n_chk++; if (err_cnt !== 8'd2) begin n_fail++; $display("FAIL at_err_cnt: got %0d want 2", err_cnt); end
    step(); settle();
    // err_clr lands in the same cycle as a new unmapped error.
    mreq(0, 1'b1, 32'h9000_0000);
    step();
    err_clr = 1'b1;
    settle(); step();
    err_clr = 1'b0;
    settle();
    n_chk++; if (m_ack_o !== 2'b01) begin n_fail++; $display("FAIL clr_ack: got %b want 01", m_ack_o); end
    n_chk++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL clr_bus_err: got %b want 1", bus_err); end
    n_chk++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL clr_err_cnt: got %0d want 1", err_cnt); end
    n_chk++; if (err_adr !== 32'h9000_0000) begin n_fail++; $display("FAIL clr_err_adr: got %h want 90000000", err_adr); end
    step();
    mreq(0, 1'b0, 32'h0);
    err_clr = 1'b1;
    settle(); step();
    err_clr = 1'b0;
    settle();
    n_chk++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL clr_only_bus_err: got %b want 0", bus_err); end
    n_chk++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL clr_only_err_cnt: got %0d want 0", err_cnt); end
    n_chk++; if (err_adr !== 32'h0) begin n_fail++; $display("FAIL clr_only_err_adr: got %h want 0", err_adr); end
  endtask

  task automatic test_reset_mid();
    mreq(0, 1'b1, 32'h0000_0200);
    step(); settle();
    n_chk++; if (s_stb_o !== 4'b1000) begin n_fail++; $display("FAIL rm_stb_pre: got %b want 1000", s_stb_o); end
    mreq(1, 1'b1, 32'h4000_0000);
    step();
    sys_rstn = 1'b0;
    settle(); step(); settle();
    n_chk++; if (s_stb_o !== 4'b0000) begin n_fail++; $display("FAIL rm_stb: got %b want 0000", s_stb_o); end
    n_chk++; if (s_cyc_o !== 4'b0000) begin n_fail++; $display("FAIL rm_cyc: got %b want 0000", s_cyc_o); end
    n_chk++; if (m_ack_o !== 2'b00) begin n_fail++; $display("FAIL rm_ack: got %b want 00", m_ack_o); end
    n_chk++; if (s_adr_o !== 32'h0) begin n_fail++; $display("FAIL rm_adr: got %h want 0", s_adr_o); end
    n_chk++; if (m_dat_o !== 64'h0) begin n_fail++; $display("FAIL rm_mdat: got %h want 0", m_dat_o); end
    n_chk++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL rm_bus_err: got %b want 0", bus_err); end
    sys_rstn = 1'b1;
    step(); settle();
    n_chk++; if (s_adr_o !== 32'h0000_0200) begin n_fail++; $display("FAIL rm_first_grant: got %h want 00000200", s_adr_o); end
    n_chk++; if (s_stb_o !== 4'b1000) begin n_fail++; $display("FAIL rm_first_stb: got %b want 1000", s_stb_o); end
    mreq(0, 1'b0, 32'h0);
    mreq(1, 1'b0, 32'h0);
    step(); step(); settle();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_read();
    test_unmapped();
    test_timeout();
    test_ack_at_timeout_and_clr();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
